riscv_mem_arbiter: RTL and testbench

Two-requester to one-port memory arbiter between `riscv_Core` and a single-port test memory. It merges the instruction port (port 0) and the data port (port 1) onto one downstream request/response channel, using round-robin arbitration with a grant lock. An in-order tag FIFO routes each downstream response back to the port that issued the request. Both directions forward combinationally, so the arbiter adds no cycles of latency.

---
 rtl/riscv_mem_arbiter.sv | 102 ++++++++++
 tb/tb_riscv_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Two-port to one-port memory arbiter: round-robin grant with a stall lock,
// plus an in-order tag FIFO that steers each downstream response back to its issuer.
module riscv_mem_arbiter #(
  parameter int p_addr_sz      = 32,
  parameter int p_data_sz      = 32,
  parameter int p_max_inflight = 4,
  localparam int RQ = 1 + p_addr_sz + 2 + p_data_sz,
  localparam int RS = 1 + 2 + p_data_sz,
  localparam int CW = $clog2(p_max_inflight) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_val,
  output logic          req0_rdy,
  input  logic [RQ-1:0] req0_msg,
  output logic          resp0_val,
  input  logic          resp0_rdy,
  output logic [RS-1:0] resp0_msg,
  input  logic          req1_val,
  output logic          req1_rdy,
  input  logic [RQ-1:0] req1_msg,
  output logic          resp1_val,
  input  logic          resp1_rdy,
  output logic [RS-1:0] resp1_msg,
  output logic          memreq_val,
  input  logic          memreq_rdy,
  output logic [RQ-1:0] memreq_msg,
  input  logic          memresp_val,
  output logic          memresp_rdy,
  input  logic [RS-1:0] memresp_msg,
  output logic [CW-1:0] inflight
);
  localparam int PW = $clog2(p_max_inflight);
  localparam logic [CW-1:0] MAX = CW'(p_max_inflight);

  logic                      r_prio;
  logic                      r_locked;
  logic                      r_lock_port;
  logic [p_max_inflight-1:0] r_tag;
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;

  logic w_full, w_empty, w_grant, w_sel_val, w_fire, w_pop, w_head;

  assign w_full  = (r_count == MAX);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_grant = r_prio;
    if (r_locked)                  w_grant = r_lock_port;
    else if (req0_val && !req1_val) w_grant = 1'b0;
    else if (req1_val && !req0_val) w_grant = 1'b1;
  end

  // Full blocks issue regardless of a same-cycle pop, so rdy never depends on rdy.
  assign w_sel_val  = w_grant ? req1_val : req0_val;
  assign memreq_val = !reset && w_sel_val && !w_full;
  assign memreq_msg = w_grant ? req1_msg : req0_msg;
  assign req0_rdy   = !reset && !w_grant && memreq_rdy && !w_full && req0_val;
  assign req1_rdy   = !reset &&  w_grant && memreq_rdy && !w_full && req1_val;
  assign w_fire     = memreq_val && memreq_rdy;

  assign w_head      = r_tag[r_rptr];
  assign resp0_val   = !reset && memresp_val && !w_empty && !w_head;
  assign resp1_val   = !reset && memresp_val && !w_empty &&  w_head;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign memresp_rdy = !reset && !w_empty && (w_head ? resp1_rdy : resp0_rdy);
  assign w_pop       = memresp_val && memresp_rdy;

  assign inflight = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_port <= 1'b0;
      r_tag       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      if (w_fire) begin
        r_tag[r_wptr] <= w_grant;
        r_wptr        <= r_wptr + PW'(1);
        r_prio        <= !w_grant;
        r_locked      <= 1'b0;
      end else if (memreq_val && !memreq_rdy) begin
        // Pin the grant so memreq_msg cannot switch under a stalled request.
        r_locked    <= 1'b1;
        r_lock_port <= w_grant;
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed and randomized bench for riscv_mem_arbiter with an in-order scoreboard
// and a 1-cycle-latency memory model.
module tb_riscv_mem_arbiter;
  localparam int RQ = 67;
  localparam int RS = 35;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic          req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [RQ-1:0] req0_msg, req1_msg, memreq_msg;
  logic [RS-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]    inflight;

  logic          mem_en = 1'b0, m_val = 1'b0, d_val = 1'b0;
  logic [RS-1:0] m_msg = '0, d_msg = '0;
  assign memresp_val = mem_en ? m_val : d_val;
  assign memresp_msg = mem_en ? m_msg : d_msg;

  riscv_mem_arbiter #(.p_addr_sz(32), .p_data_sz(32), .p_max_inflight(4)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .inflight(inflight)
  );

  function automatic logic [RQ-1:0] mk_req(input logic typ, input logic [31:0] addr,
                                            input logic [31:0] data);
    return {typ, addr, 2'd3, data};
  endfunction

  // Memory contents are a fixed function of the request so responses are traceable.
  function automatic logic [31:0] mem_data(input logic [RQ-1:0] rq);
    return rq[65:34] ^ 32'h5A5A_C3C3 ^ rq[31:0];
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [RQ-1:0] rq);
    return {rq[66], rq[33:32], mem_data(rq)};
  endfunction

  logic [RS-1:0] pend[$];
  logic          fire_log[$];
  logic [32:0]   iss_log[$];
  logic [32:0]   dlv_log[$];
  int            fires0 = 0, fires1 = 0;

  always @(posedge clk) begin
    if (reset) pend.delete();
    else begin
      if (mem_en && memresp_val && memresp_rdy && pend.size() > 0) pend.delete(0);
      if (memreq_val && memreq_rdy && mem_en) pend.push_back(mk_resp(memreq_msg));
      if (req0_val && req0_rdy) begin
        fire_log.push_back(1'b0); iss_log.push_back({1'b0, mem_data(req0_msg)}); fires0++;
      end
      if (req1_val && req1_rdy) begin
        fire_log.push_back(1'b1); iss_log.push_back({1'b1, mem_data(req1_msg)}); fires1++;
      end
      if (resp0_val && resp0_rdy) dlv_log.push_back({1'b0, resp0_msg[31:0]});
      if (resp1_val && resp1_rdy) dlv_log.push_back({1'b1, resp1_msg[31:0]});
    end
    #1;
    m_val = pend.size() > 0;
    m_msg = (pend.size() > 0) ? pend[0] : '0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    fire_log.delete(); iss_log.delete(); dlv_log.delete();
  endtask

  task automatic check_scoreboard(input string tag);
    chk({tag, "_count"}, 128'(dlv_log.size()), 128'(iss_log.size()));
    for (int i = 0; i < iss_log.size(); i++)
      chk({tag, "_resp"}, dlv_log[i], iss_log[i]);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    memreq_rdy = 0; resp0_rdy = 0; resp1_rdy = 0;
    #3;
    req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    d_val = 1; d_msg = {1'b0, 2'd3, 32'h1234_5678};
    #1;
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_req1_rdy", req1_rdy, 0);
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_resp_val", {resp0_val, resp1_val}, 0);
    chk("rst_inflight", inflight, 0);
    tick();
    req0_val = 0; req1_val = 0; memreq_rdy = 0; resp0_rdy = 0; resp1_rdy = 0; d_val = 0;
    reset = 1'b0;

    // single read on port 0
    tick();
    req0_msg = mk_req(1'b0, 32'h100, 32'h0); req0_val = 1; memreq_rdy = 1;
    #1;
    chk("t1_memreq_val", memreq_val, 1);
    chk("t1_memreq_msg", memreq_msg, req0_msg);
    chk("t1_req0_rdy", req0_rdy, 1);
    tick();
    req0_val = 0;
    #1 chk("t1_inflight1", inflight, 1);
    d_val = 1; d_msg = {1'b0, 2'd3, 32'hDEAD_BEEF}; resp0_rdy = 1;
    #1;
    chk("t1_resp0_val", resp0_val, 1);
    chk("t1_resp1_val", resp1_val, 0);
    chk("t1_resp0_msg", resp0_msg, {1'b0, 2'd3, 32'hDEAD_BEEF});
    tick();
    d_val = 0;
    #1 chk("t1_inflight0", inflight, 0);

    // contention: alternate grants starting with port 0 after reset
    pulse_reset();
    clear_logs();
    mem_en = 1; resp0_rdy = 1; resp1_rdy = 1; memreq_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      req0_val = 1; req1_val = 1;
      req0_msg = mk_req(1'b0, 32'h200 + 32'(fires0 * 4), 32'h0);
      req1_msg = mk_req(1'b1, 32'h300 + 32'(fires1 * 4), 32'h1000 + 32'(fires1));
      tick();
    end
    req0_val = 0; req1_val = 0;
    repeat (3) tick();
    chk("t2_fires", 128'(fire_log.size()), 6);
    for (int i = 0; i < fire_log.size(); i++) chk("t2_grant_order", fire_log[i], 128'(i % 2));
    check_scoreboard("t2");
    chk("t2_inflight", inflight, 0);

    // lock: port 1 stalled, port 0 arrives mid-stall
    clear_logs();
    req1_msg = mk_req(1'b1, 32'h400, 32'hAAAA); req1_val = 1; memreq_rdy = 0;
    #1;
    chk("t3_c1_val", memreq_val, 1);
    chk("t3_c1_msg", memreq_msg, req1_msg);
    chk("t3_c1_req1_rdy", req1_rdy, 0);
    tick();
    req0_msg = mk_req(1'b0, 32'h500, 32'h0); req0_val = 1;
    #1;
    chk("t3_c2_msg", memreq_msg, req1_msg);
    chk("t3_c2_req0_rdy", req0_rdy, 0);
    tick();
    #1;
    chk("t3_c3_msg", memreq_msg, req1_msg);
    chk("t3_c3_req0_rdy", req0_rdy, 0);
    tick();
    memreq_rdy = 1;
    #1;
    chk("t3_go_req1_rdy", req1_rdy, 1);
    chk("t3_go_req0_rdy", req0_rdy, 0);
    tick();
    req1_val = 0;
    #1;
    chk("t3_next_req0_rdy", req0_rdy, 1);
    chk("t3_next_msg", memreq_msg, req0_msg);
    tick();
    req0_val = 0;
    repeat (2) tick();
    chk("t3_fires", 128'(fire_log.size()), 2);
    chk("t3_order", {fire_log[0], fire_log[1]}, 2'b10);
    chk("t3_inflight", inflight, 0);

    // full FIFO blocks issue, including on the popping cycle
    mem_en = 0; d_val = 0;
    for (int i = 0; i < 4; i++) begin
      req0_val = 1; req0_msg = mk_req(1'b0, 32'h600 + 32'(i * 4), 32'h0);
      tick();
    end
    req0_msg = mk_req(1'b0, 32'h700, 32'h0);
    #1;
    chk("t4_inflight4", inflight, 4);
    chk("t4_full_memreq_val", memreq_val, 0);
    chk("t4_full_req0_rdy", req0_rdy, 0);
    d_val = 1; d_msg = {1'b0, 2'd3, 32'h0BAD_F00D}; resp0_rdy = 1;
    #1;
    chk("t4_pop_resp0_val", resp0_val, 1);
    chk("t4_pop_memresp_rdy", memresp_rdy, 1);
    chk("t4_pop_memreq_val", memreq_val, 0);
    tick();
    d_val = 0;
    #1;
    chk("t4_inflight3", inflight, 3);
    chk("t4_refire_val", memreq_val, 1);
    chk("t4_refire_rdy", req0_rdy, 1);
    tick();
    req0_val = 0;
    #1 chk("t4_inflight_refill", inflight, 4);

    // response back-pressure on port 1
    pulse_reset();
    req1_val = 1; req1_msg = mk_req(1'b0, 32'h800, 32'h0); memreq_rdy = 1;
    tick();
    req1_val = 0; d_val = 1; d_msg = {1'b0, 2'd3, 32'hCAFE_0001}; resp1_rdy = 0; resp0_rdy = 1;
    #1;
    chk("t5_resp1_val", resp1_val, 1);
    chk("t5_resp0_val", resp0_val, 0);
    chk("t5_bp_memresp_rdy", memresp_rdy, 0);
    tick();
    #1 chk("t5_hold_inflight", inflight, 1);
    resp1_rdy = 1;
    #1 chk("t5_go_memresp_rdy", memresp_rdy, 1);
    tick();
    d_val = 0;
    #1 chk("t5_inflight0", inflight, 0);

    // asynchronous reset mid-cycle with requests in flight
    req0_val = 1; req1_val = 1;
    req0_msg = mk_req(1'b0, 32'h900, 32'h0); req1_msg = mk_req(1'b1, 32'hA00, 32'h5);
    repeat (3) tick();
    req0_val = 1; req1_val = 1;
    #1 chk("t6_inflight3", inflight, 3);
    reset = 1; d_val = 1; resp0_rdy = 1; resp1_rdy = 1; memreq_rdy = 1;
    #1;
    chk("t6_async_inflight", inflight, 0);
    chk("t6_async_memreq_val", memreq_val, 0);
    chk("t6_async_req_rdy", {req0_rdy, req1_rdy}, 0);
    chk("t6_async_memresp_rdy", memresp_rdy, 0);
    chk("t6_async_resp_val", {resp0_val, resp1_val}, 0);
    tick();
    reset = 0; d_val = 0;
    #1;
    chk("t6_post_grant_msg", memreq_msg, req0_msg);
    chk("t6_post_req0_rdy", req0_rdy, 1);
    chk("t6_post_req1_rdy", req1_rdy, 0);
    tick();
    req0_val = 0; req1_val = 0;

    // randomized traffic against the in-order scoreboard
    pulse_reset();
    clear_logs();
    mem_en = 1;
    begin
      int prev0, prev1;
      prev0 = fires0; prev1 = fires1;
      for (int c = 0; c < 400; c++) begin
        if (!req0_val || fires0 != prev0) begin
          req0_val = 1'($urandom_range(0, 1));
          req0_msg = mk_req(1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        if (!req1_val || fires1 != prev1) begin
          req1_val = 1'($urandom_range(0, 1));
          req1_msg = mk_req(1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        prev0 = fires0; prev1 = fires1;
        memreq_rdy = ($urandom_range(0, 3) != 0);
        resp0_rdy  = ($urandom_range(0, 3) != 0);
        resp1_rdy  = ($urandom_range(0, 3) != 0);
        #1;
        chk("rnd_inflight", inflight, 128'(iss_log.size() - dlv_log.size()));
        chk("rnd_one_rdy", 128'(req0_rdy && req1_rdy), 0);
        tick();
      end
    end
    req0_val = 0; req1_val = 0; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    repeat (12) tick();
    check_scoreboard("rnd");
    chk("rnd_inflight_end", inflight, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
